// File: rtl/arb_pkg.sv
// Shared arbiter types and one-hot/index helpers.
// Helpers work on a fixed 16-wide vector; callers cast to their own width.
package arb_pkg;

    typedef enum logic [0:0] {StIdle, StGrant} arb_state_e;

    localparam int unsigned MaxReq = 16;
    localparam int unsigned MaxIdw = 4;

    function automatic logic [MaxIdw-1:0] onehot_to_idx(input logic [MaxReq-1:0] onehot);
        logic [MaxIdw-1:0] idx;
        idx = '0;
        for (int i = 0; i < MaxReq; i++) begin
            if (onehot[i]) idx = idx | MaxIdw'(i);
        end
        return idx;
    endfunction

    function automatic logic [MaxReq-1:0] idx_to_onehot(input logic [MaxIdw-1:0] idx);
        logic [MaxReq-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: rotate req by ptr, find first set bit, map back to
// the original requester index.
module rr_priority_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any_req
);

    localparam logic [IDW:0] NW = (IDW+1)'(N);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   pos;
    logic [IDW:0]   sum;
    logic           found;

    always_comb begin
        rot   = '0;
        off   = '0;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IDW+1)'(i);
            if (pos >= NW) pos = pos - NW;
            rot[i] = req[pos[IDW-1:0]];
        end
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NW) sum = sum - NW;
        winner  = sum[IDW-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: registered one-hot grant held for up to MAX_BURST
// cycles, one idle turnaround cycle between bursts.
module rr_burst_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned IDW       = $clog2(N)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N-1:0]                     req,
    input  logic [N-1:0]                     rel,
    output logic [N-1:0]                     gnt,
    output logic [IDW-1:0]                   gnt_id,
    output logic                             gnt_valid,
    output logic [$clog2(MAX_BURST+1)-1:0]   burst_cnt
);
    import arb_pkg::*;

    localparam int unsigned CW = $clog2(MAX_BURST+1);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] pick_id;
    logic           any_req;
    logic           burst_end;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (pick_id),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Release, request drop and expiry collapse into one end event.
    assign burst_end = rel[gnt_id_q] | ~req[gnt_id_q] | (cnt_q == CW'(MAX_BURST-1));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d  = StGrant;
                    gnt_d    = N'(idx_to_onehot(MaxIdw'(pick_id)));
                    gnt_id_d = pick_id;
                    cnt_d    = '0;
                end
            end
            StGrant: begin
                if (burst_end) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    cnt_d    = '0;
                    ptr_d    = (gnt_id_q == IDW'(N-1)) ? '0 : gnt_id_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                gnt_d    = '0;
                gnt_id_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_id    = gnt_id_q;
        gnt_valid = |gnt_q;
        burst_cnt = cnt_q;
    end

    gnt_onehot_a: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    gnt_id_match_a: assert property (@(posedge clk) disable iff (reset)
        gnt_valid |-> onehot_to_idx(MaxReq'(gnt)) == MaxIdw'(gnt_id));
    gnt_id_idle_a: assert property (@(posedge clk) disable iff (reset)
        !gnt_valid |-> gnt_id == '0);

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter with N=4, MAX_BURST=4.
module tb_rr_burst_arbiter;

    localparam int unsigned N         = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned IDW       = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   rel;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic [2:0]     burst_cnt;

    int checks;
    int failures;

    rr_burst_arbiter #(
        .N         (N),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        rel   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = '0;
        rel      = '0;

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        check("rst_burst_cnt", 32'(burst_cnt), 32'h0);
        check("rst_ptr", 32'(dut.ptr_q), 32'h0);

        // 1. Basic grant and release
        req = 4'b0101;
        tick();
        check("t1_gnt_c1", 32'(gnt), 32'h1);
        check("t1_cnt_c1", 32'(burst_cnt), 32'h0);
        tick();
        check("t1_gnt_c2", 32'(gnt), 32'h1);
        tick();
        check("t1_gnt_c3", 32'(gnt), 32'h1);
        check("t1_cnt_c3", 32'(burst_cnt), 32'h2);
        rel = 4'b0001;
        tick();
        rel = '0;
        check("t1_idle_gnt", 32'(gnt), 32'h0);
        check("t1_idle_valid", 32'(gnt_valid), 32'h0);
        check("t1_ptr", 32'(dut.ptr_q), 32'h1);
        tick();
        check("t1_gnt2", 32'(gnt), 32'h4);
        check("t1_gnt2_id", 32'(gnt_id), 32'h2);

        // 2. Full rotation
        do_reset();
        req = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("t2_gnt", 32'(gnt), 32'(1 << b));
                check("t2_cnt", 32'(burst_cnt), 32'(c));
                check("t2_id", 32'(gnt_id), 32'(b));
            end
            tick();
            check("t2_idle", 32'(gnt), 32'h0);
        end
        tick();
        check("t2_wrap", 32'(gnt), 32'h1);

        // 3. Sole requester expiry
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t3_gnt", 32'(gnt), 32'h2);
            check("t3_id", 32'(gnt_id), 32'h1);
        end
        tick();
        check("t3_idle", 32'(gnt), 32'h0);
        tick();
        check("t3_regrant", 32'(gnt), 32'h2);

        // 4. Request drop
        do_reset();
        req = 4'b1100;
        tick();
        check("t4_gnt_c1", 32'(gnt), 32'h4);
        tick();
        check("t4_gnt_c2", 32'(gnt), 32'h4);
        req = 4'b1000;
        tick();
        check("t4_idle", 32'(gnt), 32'h0);
        tick();
        check("t4_next", 32'(gnt), 32'h8);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t4_no2", 32'(gnt[2]), 32'h0);
        end

        // 5. Reset mid-burst
        do_reset();
        req = 4'b1000;
        tick();
        tick();
        tick();
        check("t5_pre_gnt", 32'(gnt), 32'h8);
        check("t5_pre_cnt", 32'(burst_cnt), 32'h2);
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_cnt", 32'(burst_cnt), 32'h0);
        check("t5_rst_ptr", 32'(dut.ptr_q), 32'h0);
        reset = 1'b0;
        tick();
        check("t5_first", 32'(gnt), 32'h1);

        // 6a. Stray release bits ignored
        do_reset();
        req = 4'b1111;
        tick();
        rel = 4'b1110;
        for (int c = 1; c < 4; c++) begin
            tick();
            check("t6a_gnt", 32'(gnt), 32'h1);
            check("t6a_cnt", 32'(burst_cnt), 32'(c));
        end
        tick();
        rel = '0;
        check("t6a_end", 32'(gnt), 32'h0);
        check("t6a_ptr", 32'(dut.ptr_q), 32'h1);

        // 6b. Release coincident with expiry
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        tick();
        tick();
        check("t6b_cnt3", 32'(burst_cnt), 32'h3);
        rel = 4'b0001;
        tick();
        rel = '0;
        check("t6b_end", 32'(gnt), 32'h0);
        check("t6b_ptr", 32'(dut.ptr_q), 32'h1);
        tick();
        check("t6b_next", 32'(gnt), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
